// File: rtl/shift_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl_pkg
// Shared encodings for the iterative ALU shift sequencer.
//   - Shift operation codes as seen on in_op (2'b10 is reserved and is
//     executed as a logical right shift).
//   - FSM state encoding for shift_seq_ctrl.
//   - Small helpers used by the controller and its shift stage.
// ---------------------------------------------------------------------------
package shift_seq_ctrl_pkg;

  // Operation encodings
  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_RSV = 2'b10;
  localparam logic [1:0] SHIFT_SRA = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True when the operation fills vacated bits with the sign bit.
  function automatic logic is_arith(input logic [1:0] op);
    return (op == SHIFT_SRA);
  endfunction

  // True when the operation moves bits towards the MSB.
  function automatic logic is_left(input logic [1:0] op);
    return (op == SHIFT_SLL);
  endfunction

endpackage : shift_seq_ctrl_pkg

// File: rtl/shift_seq_ctrl_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Bounded per-cycle shift stage used by shift_seq_ctrl. Purely combinational.
//
// Parameters
//   N    : datapath width in bits
//   STEP : largest shift distance this stage must support per cycle
//   KW   : width of the k input, wide enough to hold 0..STEP
//
// Ports
//   acc : operand to shift
//   k   : shift distance, 0..STEP
//   op  : operation code (SLL / SRL / SRA; the reserved code acts as SRL)
//   z   : acc shifted by k according to op
// ---------------------------------------------------------------------------
module shift_step
  import shift_seq_ctrl_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 8,
  parameter int KW   = $clog2(STEP + 1)
) (
  input  logic [N-1:0]  acc,
  input  logic [KW-1:0] k,
  input  logic [1:0]    op,
  output logic [N-1:0]  z
);

  always_comb begin
    z = acc >> k;
    if (is_left(op)) begin
      z = acc << k;
    end else if (is_arith(op)) begin
      // Arithmetic shift replicates the current MSB into vacated bits.
      z = $unsigned($signed(acc) >>> k);
    end
  end

endmodule : shift_step

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
// Multi-cycle shift sequencer for the ALU shift path. Accepts one request
// per valid/ready handshake, applies SLL/SRL/SRA in chunks of at most STEP
// bits per cycle through shift_step, then holds the result until taken.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is high only in IDLE; out_valid
// is high only in DONE and, once high, stays high with out_z stable until
// out_ready is seen. Input operands are sampled on the accept edge only.
//
// Parameters
//   N    : datapath width (power of two)
//   STEP : maximum shift distance applied per cycle (1..N-1)
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset
//   in_valid  : request present
//   in_ready  : block can accept a request (IDLE and not in reset)
//   in_x      : operand to shift
//   in_s      : unsigned shift amount
//   in_op     : 00 SLL, 01 SRL, 11 SRA, 10 reserved (runs as SRL)
//   out_valid : result available (DONE)
//   out_ready : consumer takes the result
//   out_z     : shift result
//   busy      : high in SHIFT or DONE
//
// Latency from accept edge to out_valid: 1 edge when in_s is 0 or >= N,
// otherwise 1 + ceil(in_s / STEP) edges.
// ---------------------------------------------------------------------------
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [31:0]  in_s,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_z,
  output logic         busy
);

  localparam int LOG2N = $clog2(N);
  // One extra bit so the remaining count can hold N-1 without any wrap.
  localparam int RW    = LOG2N + 1;
  localparam int KW    = $clog2(STEP + 1);

  localparam logic [RW-1:0] STEP_R = RW'(STEP);

  state_t        state;
  state_t        state_next;

  logic [N-1:0]  acc;
  logic [N-1:0]  acc_next;
  logic [RW-1:0] rem;
  logic [RW-1:0] rem_next;
  logic [RW-1:0] rem_after;
  logic [1:0]    op_q;
  logic [1:0]    op_next;

  logic          accept;
  logic          s_big;
  logic          s_zero;
  logic [KW-1:0] k;
  logic [N-1:0]  step_z;

  assign accept = in_valid && in_ready;
  assign s_big  = (in_s >= 32'(N));
  assign s_zero = (in_s == 32'd0);

  // Chunk applied this cycle: min(rem, STEP).
  always_comb begin
    k = KW'(rem);
    if (rem > STEP_R) begin
      k = KW'(STEP);
    end
  end

  assign rem_after = rem - RW'(k);

  shift_step #(
    .N    (N),
    .STEP (STEP),
    .KW   (KW)
  ) u_step (
    .acc (acc),
    .k   (k),
    .op  (op_q),
    .z   (step_z)
  );

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          // Zero and out-of-range amounts resolve in the accept cycle.
          if (s_big || s_zero) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (rem_after == '0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // rst gates in_ready combinationally so nothing is accepted while the
    // reset is still asserted.
    in_ready  = (state == ST_IDLE) && !rst;
    out_valid = (state == ST_DONE);
    busy      = (state == ST_SHIFT) || (state == ST_DONE);
    out_z     = acc;
  end

  // -------------------------------------------------------------------------
  // Datapath: accumulator, remaining count and latched operation
  // -------------------------------------------------------------------------
  always_comb begin
    acc_next = acc;
    rem_next = rem;
    op_next  = op_q;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          op_next = in_op;
          if (s_big) begin
            acc_next = is_arith(in_op) ? {N{in_x[N-1]}} : '0;
            rem_next = '0;
          end else if (s_zero) begin
            acc_next = in_x;
            rem_next = '0;
          end else begin
            // Upper bits of in_s are zero here, so only the low bits matter.
            acc_next = in_x;
            rem_next = RW'(in_s[LOG2N-1:0]);
          end
        end
      end
      ST_SHIFT: begin
        acc_next = step_z;
        rem_next = rem_after;
      end
      default: begin
        // DONE holds acc so out_z stays stable under backpressure.
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      rem  <= '0;
      op_q <= SHIFT_SRL;
    end else begin
      acc  <= acc_next;
      rem  <= rem_next;
      op_q <= op_next;
    end
  end

endmodule : shift_seq_ctrl

// File: tb/tb_shift_seq_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Directed bench for shift_seq_ctrl with N=32, STEP=8. Expected results and
// latencies are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_s;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic        busy;

  int tests_run;
  int tests_failed;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_RSV = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  shift_seq_ctrl #(
    .N    (32),
    .STEP (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_s      (in_s),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .busy      (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request at the falling edge and let the next rising edge
  // accept it; returns #1 after the accept edge with in_valid dropped.
  task automatic start_req(input string tag, input logic [31:0] x,
                           input logic [31:0] s, input logic [1:0] op);
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = x;
    in_s     = s;
    in_op    = op;
    #1;
    check({tag, "_in_ready_before"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x     = 32'hDEAD_BEEF;
    in_s     = 32'd5;
    in_op    = OP_SLL;
  endtask

  // Count edges from accept until out_valid, checking busy/in_ready while
  // waiting, then check latency and result.
  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_z);
    int lat;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      check({tag, "_busy_wait"}, {31'd0, busy}, 32'd1);
      check({tag, "_in_ready_wait"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_out_z"}, out_z, exp_z);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
  endtask

  // Take the result and confirm return to IDLE.
  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_after_take"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_after_take"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_busy_after_take"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_req(input string tag, input logic [31:0] x, input logic [31:0] s,
                         input logic [1:0] op, input int exp_lat, input logic [31:0] exp_z);
    start_req(tag, x, s, op);
    wait_done(tag, exp_lat, exp_z);
    release_out(tag);
  endtask

  initial begin
    logic [31:0] held_z;
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_s      = '0;
    in_op     = OP_SLL;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_z", out_z, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: SRL -10 by 23
    run_req("srl23", 32'hFFFF_FFF6, 32'd23, OP_SRL, 4, 32'h0000_01FF);
    // 2: zero amount, short SRA
    run_req("srl0", 32'h0000_0008, 32'd0, OP_SRL, 1, 32'h0000_0008);
    run_req("sra3", 32'hFFFF_FFF1, 32'd3, OP_SRA, 2, 32'hFFFF_FFFE);
    // 3: maximum in-range amount
    run_req("sll31", 32'h0000_0007, 32'd31, OP_SLL, 5, 32'h8000_0000);
    run_req("srl31", 32'hFFFF_FFFF, 32'd31, OP_SRL, 5, 32'h0000_0001);
    // 4: out-of-range amounts
    run_req("srl32", 32'hFFFF_FFFF, 32'd32, OP_SRL, 1, 32'h0000_0000);
    run_req("sra40", 32'hFFFF_FFFF, 32'd40, OP_SRA, 1, 32'hFFFF_FFFF);
    run_req("sra32p", 32'h7FFF_FFFF, 32'd32, OP_SRA, 1, 32'h0000_0000);
    run_req("sll_big", 32'h0000_0001, 32'h0001_0003, OP_SLL, 1, 32'h0000_0000);
    // Reserved op behaves as SRL; exactly STEP bits, and STEP+1 bits
    run_req("rsv4", 32'h8000_0000, 32'd4, OP_RSV, 2, 32'h0800_0000);
    run_req("sll8", 32'h0000_00A5, 32'd8, OP_SLL, 2, 32'h0000_A500);
    run_req("sra9", 32'h8000_0000, 32'd9, OP_SRA, 3, 32'hFFC0_0000);

    // 5: backpressure with competing input traffic
    start_req("bp", 32'h0000_0007, 32'd31, OP_SLL);
    wait_done("bp", 5, 32'h8000_0000);
    held_z = out_z;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x     = 32'h1234_5678 + 32'(i);
      in_s     = 32'd1 + 32'(i);
      in_op    = OP_SRL;
      @(posedge clk);
      #1;
      check("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
      check("bp_out_z_hold", out_z, held_z);
      check("bp_no_accept", {31'd0, in_ready}, 32'd0);
    end
    // Release while a new request (0x100 >> 4) is waiting on the input.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_x      = 32'h0000_0100;
    in_s      = 32'd4;
    in_op     = OP_SRL;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_leave_done", {31'd0, out_valid}, 32'd0);
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_accepted", {31'd0, in_ready}, 32'd0);
    wait_done("bp_next", 2, 32'h0000_0010);
    release_out("bp_next");

    // 6: reset during the second SHIFT cycle of an s=23 request
    start_req("mid", 32'hFFFF_FFF6, 32'd23, OP_SRL);
    @(posedge clk);
    #1;
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    check("mid_acc_pre", out_z, 32'h00FF_FFFF);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_out_z", out_z, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_req("post_rst", 32'h0000_000C, 32'd2, OP_SRL, 2, 32'h0000_0003);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule : tb_shift_seq_ctrl

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Multi-cycle shift sequencer for the ALU shift path. It accepts one shift request through a valid/ready handshake and executes SLL, SRL or SRA iteratively through a small per-cycle shift stage. It then holds the result under a valid/ready output handshake. This lets the ALU replace the full single-cycle barrel shifter with a cheaper bounded stage, at the cost of a data-dependent latency.

Parameters:
N, 32, datapath width in bits (power of two)
STEP, 8, maximum shift distance applied per cycle (1..N-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  request present
in_ready  out  1  block can accept a request
in_x  in  N  operand to shift
in_s  in  32  shift amount, unsigned
in_op  in  2  operation: 00 SLL, 01 SRL, 11 SRA, 10 reserved (executes as SRL)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_z  out  N  shift result
busy  out  1  high in SHIFT or DONE

Behaviour:
- Interface: one clock (clk); rst is asynchronous, active-high. While rst is high:
  - state=IDLE, acc=0, rem=0, op_q=SRL
  - out_valid=0, out_z=0, busy=0, in_ready=0
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE) and not rst. out_valid = (state==DONE). out_z = acc, held constant throughout DONE.
- IDLE, accept on the edge where in_valid and in_ready are both high; latch op_q=in_op.
  - in_s >= N: acc = 0 for SLL/SRL, or N copies of in_x[N-1] for SRA; rem=0; next state DONE.
  - in_s == 0: acc=in_x, next state DONE.
  - Otherwise: acc=in_x, rem=in_s[log2(N)-1:0], next state SHIFT.
- SHIFT, each edge:
  - k = min(rem, STEP); acc = acc shifted by k per op_q (SRA fills with acc[N-1]); rem = rem-k.
  - Go to DONE on the edge where rem-k == 0.
- DONE: on the edge where out_ready is high, go to IDLE. The next request can be accepted on the following edge (no same-edge overlap).
- Latency, counted in edges from accept until out_valid is high:
  - 1 for in_s==0 or in_s>=N
  - otherwise 1+ceil(in_s/STEP)
  - Worked values for N=32, STEP=8: s=23 gives 4; s=31 gives 5; s=3 gives 2.
- Input side: in_valid outside IDLE is ignored; in_x, in_s and in_op are sampled only on the accept edge, and later changes have no effect.
- Output side: out_ready while not in DONE is ignored. out_valid stays high indefinitely until out_ready (no drop, no change to out_z).
- Reset mid-operation (SHIFT or DONE): the result is abandoned, outputs go to their reset values immediately (asynchronous), and the block restarts in IDLE after rst deasserts.
- Arithmetic: all shifts are zero-fill except SRA. rem width is log2(N)+1, so no wrap is possible. in_s bits above log2(N)-1 only matter through the >=N check.

Decomposition:
- Shared defines file alu_defines.v holds:
  - op encodings (SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b11)
  - state encodings (ST_IDLE, ST_SHIFT, ST_DONE)
- One natural sub-module, shift_step, parameterised by N and STEP:
  - purely combinational
  - takes acc, k (0..STEP) and op; returns acc shifted by k
- shift_seq_ctrl contains only the FSM, the rem counter and the acc register.

Test Plan (N=32, STEP=8):
1. SRL, in_x=0xFFFFFFF6 (-10), in_s=23 -> out_z=0x000001FF; out_valid high 4 edges after accept; in_ready=0 and busy=1 meanwhile.
2. SRL, in_x=8, in_s=0 -> out_z=0x00000008 after 1 edge. SRA, in_x=0xFFFFFFF1 (-15), in_s=3 -> out_z=0xFFFFFFFE after 2 edges.
3. SLL, in_x=7, in_s=31 -> out_z=0x80000000 after 5 edges. SRL, in_x=0xFFFFFFFF, in_s=31 -> out_z=0x00000001.
4. Out-of-range amounts, each after 1 edge:
   - SRL, in_x=0xFFFFFFFF, in_s=32 -> out_z=0x00000000
   - SRA, in_x=0xFFFFFFFF, in_s=40 -> out_z=0xFFFFFFFF
   - SRA, in_x=0x7FFFFFFF, in_s=32 -> out_z=0x00000000
5. Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> out_z is stable, out_valid stays 1, no new accept. Raise out_ready -> IDLE; the next request is accepted one edge later.
6. Reset mid-operation: assert rst during the second SHIFT cycle of an s=23 request -> out_valid, busy and out_z go to 0 immediately with no clock. After deassert, a fresh SRL with in_x=12, in_s=2 -> out_z=0x00000003 after 2 edges.
